// File: rtl/cgra_defs.sv
// rtl/cgra_defs.sv - shared definitions for the SCGRA PE array run controller
package cgra_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int DEF_INST_AWIDTH  = 10;
    localparam int DEF_DRAIN_CYCLES = 6;
    localparam int DEF_CWIDTH       = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clr_i   clear to zero (wins over enable)
//   en_i    count enable
//   cnt_o   current count, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(&cnt_q)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - run controller: instruction fetch sequencing, drain and completion
//
// Ports:
//   Clk, Resetn     clock, asynchronous active-low reset
//   Start, Inst_Num run request and instruction count, sampled in IDLE only
//   Abort           terminate a run in RUN or DRAIN without a Done pulse
//   Inst_Addr       instruction address broadcast to all PEs
//   Inst_Rd_En      instruction fetch valid
//   PE_Array_Busy   high through fetch and drain
//   Done            one-cycle completion pulse
//   Cycle_Cnt       busy cycles of the last or current run
module pe_array_ctrl
    import cgra_defs::*;
#(
    parameter int INST_AWIDTH  = DEF_INST_AWIDTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CWIDTH       = DEF_CWIDTH
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Start,
    input  logic [INST_AWIDTH:0]   Inst_Num,
    input  logic                   Abort,
    output logic [INST_AWIDTH-1:0] Inst_Addr,
    output logic                   Inst_Rd_En,
    output logic                   PE_Array_Busy,
    output logic                   Done,
    output logic [CWIDTH-1:0]      Cycle_Cnt
);

    // Drain counter needs at least one bit even when DRAIN_CYCLES is 1.
    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [INST_AWIDTH-1:0] addr_q, addr_d;
    logic [INST_AWIDTH:0]   num_q, num_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   cnt_clr;
    logic                   last_fetch;

    // Num_Reg is one bit wider than the address so a full-depth run compares
    // against 2^INST_AWIDTH-1 without the address ever having to wrap.
    assign last_fetch = ({1'b0, addr_q} == (num_q - (INST_AWIDTH+1)'(1)));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        num_d   = num_q;
        drain_d = drain_q;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    cnt_clr = 1'b1;
                    if (Inst_Num != '0) begin
                        num_d   = Inst_Num;
                        addr_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if (last_fetch) begin
                    drain_d = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + INST_AWIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            num_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            drain_q <= drain_d;
        end
    end

    assign Inst_Addr     = addr_q;
    assign Inst_Rd_En    = (state_q == ST_RUN);
    assign PE_Array_Busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign Done          = (state_q == ST_DONE);

    sat_counter #(
        .WIDTH(CWIDTH)
    ) u_cycle_cnt (
        .clk_i (Clk),
        .rst_ni(Resetn),
        .clr_i (cnt_clr),
        .en_i  (PE_Array_Busy),
        .cnt_o (Cycle_Cnt)
    );

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed self-checking bench for pe_array_ctrl
module tb_pe_array_ctrl;

    logic        Clk;
    logic        Resetn;
    logic        Start;
    logic [10:0] Inst_Num;
    logic        Abort;
    logic [9:0]  Inst_Addr;
    logic        Inst_Rd_En;
    logic        PE_Array_Busy;
    logic        Done;
    logic [31:0] Cycle_Cnt;

    int tests_run;
    int tests_failed;

    int         busy_cnt;
    int         rd_cnt;
    int         done_cnt;
    int         done_idx;
    int         addr_err;
    int         hold_err;
    logic [9:0] last_addr;

    pe_array_ctrl dut (
        .Clk          (Clk),
        .Resetn       (Resetn),
        .Start        (Start),
        .Inst_Num     (Inst_Num),
        .Abort        (Abort),
        .Inst_Addr    (Inst_Addr),
        .Inst_Rd_En   (Inst_Rd_En),
        .PE_Array_Busy(PE_Array_Busy),
        .Done         (Done),
        .Cycle_Cnt    (Cycle_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Watches ncyc cycles starting with the current one; Start is held high
    // for cycle indices s0..s1 and Abort for cycle index a0.
    task automatic observe(input int ncyc, input int s0, input int s1, input int a0);
        busy_cnt  = 0;
        rd_cnt    = 0;
        done_cnt  = 0;
        done_idx  = -1;
        addr_err  = 0;
        hold_err  = 0;
        last_addr = '0;
        for (int c = 0; c < ncyc; c++) begin
            Start = (c >= s0) && (c <= s1);
            Abort = (c == a0);
            if (PE_Array_Busy === 1'b1) busy_cnt++;
            if (Inst_Rd_En === 1'b1) begin
                if (Inst_Addr !== 10'(rd_cnt)) addr_err++;
                last_addr = Inst_Addr;
                rd_cnt++;
            end else if (PE_Array_Busy === 1'b1 && Inst_Addr !== last_addr) begin
                hold_err++;
            end
            if (Done === 1'b1) begin
                done_cnt++;
                done_idx = c;
            end
            step();
        end
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic launch(input logic [10:0] n);
        Inst_Num = n;
        Start    = 1'b1;
        step();
        Start    = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Resetn   = 1'b0;
        Start    = 1'b0;
        Abort    = 1'b0;
        Inst_Num = '0;

        // Reset state
        #12;
        chk("rst_addr", 64'(Inst_Addr), 64'd0);
        chk("rst_rden", 64'(Inst_Rd_En), 64'd0);
        chk("rst_busy", 64'(PE_Array_Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_cnt", 64'(Cycle_Cnt), 64'd0);
        step();
        Resetn = 1'b1;
        step();

        // Basic run: 4 instructions + 6 drain cycles
        launch(11'd4);
        chk("basic_first_rden", 64'(Inst_Rd_En), 64'd1);
        chk("basic_first_addr", 64'(Inst_Addr), 64'd0);
        observe(14, -1, -2, -1);
        chk("basic_busy", 64'(busy_cnt), 64'd10);
        chk("basic_rd", 64'(rd_cnt), 64'd4);
        chk("basic_addr_seq", 64'(addr_err), 64'd0);
        chk("basic_hold", 64'(hold_err), 64'd0);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        chk("basic_done_idx", 64'(done_idx), 64'd10);
        chk("basic_cycle_cnt", 64'(Cycle_Cnt), 64'd10);

        // Zero-length run
        launch(11'd0);
        chk("zero_done_now", 64'(Done), 64'd1);
        observe(4, -1, -2, -1);
        chk("zero_busy", 64'(busy_cnt), 64'd0);
        chk("zero_rd", 64'(rd_cnt), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);
        chk("zero_cycle_cnt", 64'(Cycle_Cnt), 64'd0);

        // Start during RUN and DRAIN is ignored
        launch(11'd4);
        Inst_Num = 11'd8;
        observe(14, 2, 7, -1);
        chk("ign_busy", 64'(busy_cnt), 64'd10);
        chk("ign_rd", 64'(rd_cnt), 64'd4);
        chk("ign_done_cnt", 64'(done_cnt), 64'd1);
        chk("ign_done_idx", 64'(done_idx), 64'd10);
        chk("ign_cycle_cnt", 64'(Cycle_Cnt), 64'd10);

        // Abort in second DRAIN cycle
        launch(11'd4);
        observe(12, -1, -2, 5);
        chk("abort_busy", 64'(busy_cnt), 64'd6);
        chk("abort_done_cnt", 64'(done_cnt), 64'd0);
        chk("abort_cycle_cnt", 64'(Cycle_Cnt), 64'd6);
        launch(11'd2);
        observe(12, -1, -2, -1);
        chk("post_abort_busy", 64'(busy_cnt), 64'd8);
        chk("post_abort_rd", 64'(rd_cnt), 64'd2);
        chk("post_abort_done_idx", 64'(done_idx), 64'd8);
        chk("post_abort_cycle_cnt", 64'(Cycle_Cnt), 64'd8);

        // Full depth: 1024 instructions, no address wrap
        launch(11'd1024);
        observe(1035, -1, -2, -1);
        chk("full_busy", 64'(busy_cnt), 64'd1030);
        chk("full_rd", 64'(rd_cnt), 64'd1024);
        chk("full_addr_seq", 64'(addr_err), 64'd0);
        chk("full_hold", 64'(hold_err), 64'd0);
        chk("full_last_addr", 64'(last_addr), 64'd1023);
        chk("full_done_idx", 64'(done_idx), 64'd1030);
        chk("full_cycle_cnt", 64'(Cycle_Cnt), 64'd1030);

        // Reset asserted in cycle 3 of RUN
        launch(11'd8);
        step();
        step();
        chk("mid_addr_before_rst", 64'(Inst_Addr), 64'd2);
        #2;
        Resetn = 1'b0;
        #1;
        chk("mid_rst_addr", 64'(Inst_Addr), 64'd0);
        chk("mid_rst_rden", 64'(Inst_Rd_En), 64'd0);
        chk("mid_rst_busy", 64'(PE_Array_Busy), 64'd0);
        chk("mid_rst_done", 64'(Done), 64'd0);
        chk("mid_rst_cnt", 64'(Cycle_Cnt), 64'd0);
        step();
        Resetn = 1'b1;
        observe(6, -1, -2, -1);
        chk("mid_idle_busy", 64'(busy_cnt), 64'd0);
        chk("mid_idle_done", 64'(done_cnt), 64'd0);
        launch(11'd3);
        observe(12, -1, -2, -1);
        chk("mid_rerun_busy", 64'(busy_cnt), 64'd9);
        chk("mid_rerun_rd", 64'(rd_cnt), 64'd3);
        chk("mid_rerun_done_idx", 64'(done_idx), 64'd9);
        chk("mid_rerun_cycle_cnt", 64'(Cycle_Cnt), 64'd9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Run controller for the SCGRA PE array. It accepts a start request from the host-side interface and generates the shared instruction address and read enable for every PE's instruction memory. It drives `PE_Array_Busy` to all PEs, waits for the PE pipeline to drain, then signals completion. One instance sits at the array top, between the host control registers and the PE/PEIO grid.

## Interface
- `INST_AWIDTH`, 10: instruction memory address width. Depth is 2^INST_AWIDTH.
- `DRAIN_CYCLES`, 6: cycles `PE_Array_Busy` stays high after the last instruction fetch (2 instruction registers, memory read, ALU, output register, margin). Must be ≥1.
- `CWIDTH`, 32: width of the performance cycle counter.

Ports:
- `Clk`  in  1  single clock.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  run request, sampled only in IDLE.
- `Inst_Num`  in  INST_AWIDTH+1  number of instructions to issue (0..2^INST_AWIDTH), sampled with `Start`.
- `Abort`  in  1  terminate the current run.
- `Inst_Addr`  out  INST_AWIDTH  instruction address broadcast to all PEs.
- `Inst_Rd_En`  out  1  instruction fetch valid.
- `PE_Array_Busy`  out  1  array executing (fetch or drain).
- `Done`  out  1  one-cycle completion pulse.
- `Cycle_Cnt`  out  CWIDTH  busy cycles of the last or current run.

## Operation
- Moore FSM with states IDLE, RUN, DRAIN, DONE. All outputs are registers or decodes of the state register; they are glitch-free.
- **IDLE**
  - On `Start`=1 with `Inst_Num`≠0: latch `Inst_Num` into `Num_Reg`, clear `Inst_Addr` and `Cycle_Cnt`, go to RUN.
  - On `Start`=1 with `Inst_Num`=0: clear `Cycle_Cnt` and go directly to DONE.
- **RUN**
  - `Inst_Rd_En`=1, `PE_Array_Busy`=1.
  - `Inst_Addr` increments by 1 each cycle.
  - When `Inst_Addr`==`Num_Reg`-1: load the drain counter with DRAIN_CYCLES-1 and go to DRAIN. `Inst_Addr` holds its last value; it never wraps to 0 within a run, including when `Inst_Num`=2^INST_AWIDTH.
- **DRAIN**
  - `Inst_Rd_En`=0, `PE_Array_Busy`=1.
  - Drain counter decrements each cycle; at 0, go to DONE.
- **DONE**
  - `Done`=1 for exactly one cycle, `PE_Array_Busy`=0, then return to IDLE.
- **Cycle_Cnt**
  - Increments every cycle in RUN or DRAIN.
  - Saturates at all-ones.
  - Holds its value in IDLE and DONE until the next accepted `Start`.
- **Start** outside IDLE is ignored (no queuing). **Start** in DONE is also ignored.
- **Abort**
  - In RUN or DRAIN: go to IDLE on the next edge, with no `Done` pulse. `Cycle_Cnt` holds its count.
  - In IDLE or DONE: no effect. A DONE pulse is not suppressed.
  - `Abort` has priority over every RUN/DRAIN transition.
- **Reset values:** state IDLE, `Inst_Addr`=0, `Inst_Rd_En`=0, `PE_Array_Busy`=0, `Done`=0, `Cycle_Cnt`=0, `Num_Reg`=0. Reset asserted mid-run returns all of these to reset values immediately (asynchronous).

## Timing
- `Start` sampled at edge k → `Inst_Rd_En`=1 and `Inst_Addr`=0 after edge k.
- Address n is presented in cycle k+n.
- `PE_Array_Busy` is high for exactly `Inst_Num`+DRAIN_CYCLES cycles.
- `Done` is high in the cycle immediately after busy falls.
- `Inst_Num`=0: `Done` is high in the cycle after edge k, and busy never rises.
- Minimum Start-to-Start spacing is `Inst_Num`+DRAIN_CYCLES+2 cycles. The next `Start` may be sampled in the IDLE cycle following DONE.
- Each PE's instruction memory adds its own read latency plus two register stages. DRAIN_CYCLES covers these, so the last instruction's store completes while busy is still high.

## Structure
- Shared package/header `cgra_defs` holds:
  - state encodings (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10, DONE=2'b11);
  - default INST_AWIDTH;
  - default DRAIN_CYCLES.
- A single sub-module `sat_counter` (parameterised width, clear, enable, saturate) is natural for `Cycle_Cnt`. The rest is flat.

## Test plan
- **Basic run:** `Inst_Num`=4, DRAIN_CYCLES=6, `Start` pulse → `Inst_Addr` 0,1,2,3 with `Inst_Rd_En` high 4 cycles, busy high 10 cycles, one `Done` pulse, `Cycle_Cnt`=10.
- **Zero-length run:** `Inst_Num`=0 → `Done` the next cycle, busy and `Inst_Rd_En` never high, `Cycle_Cnt`=0.
- **Full depth:** `Inst_Num`=1024 (INST_AWIDTH=10) → addresses 0..1023 with no wrap, busy for 1030 cycles, `Cycle_Cnt`=1030.
- **Start during run:** `Start` with `Inst_Num`=8 during RUN and DRAIN of a 4-instruction run → ignored; busy still 10 cycles; `Num_Reg` unchanged; exactly one `Done`.
- **Abort:** `Abort` in the 2nd DRAIN cycle of the basic run → IDLE next edge, no `Done`, `Cycle_Cnt`=6. A following `Start` with `Inst_Num`=2 runs normally.
- **Reset mid-run:** `Resetn` low in cycle 3 of RUN → all outputs 0 immediately. After release, the FSM waits in IDLE until a fresh `Start`.
